// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave responder: FSM state encoding and transfer direction.
package i2c_pkg;

    // Slave protocol states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_DATA  = 3'd3,
        WR_ACK   = 3'd4,
        RD_DATA  = 3'd5,
        RD_ACK   = 3'd6,
        IGNORE   = 3'd7
    } i2c_state_t;

    // R/W bit of the address byte
    typedef enum logic {
        I2C_WRITE = 1'b0,
        I2C_READ  = 1'b1
    } i2c_op_t;

    // Wide enough to count up to a full byte (value 8 is used while serving reads)
    localparam int unsigned BIT_CNT_W = 4;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for an asynchronous bus line plus rise/fall detection.
// Flops reset to 1 so an idle (pulled-up) bus produces no edge on reset release.
module i2c_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [1:0] sync_q;
    logic       prev_q;

    // Synchronize the bus line and keep one cycle of history for edge detection
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[0], d_i};
            prev_q <= sync_q[1];
        end
    end

    assign level_o = sync_q[1];
    assign rise_o  = sync_q[1] & ~prev_q;
    assign fall_o  = ~sync_q[1] & prev_q;

endmodule

// File: rtl/i2c_slave_if.sv
// Single-address I2C slave responder with a byte-wide user interface.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | bus free, waiting for START
// ADDR     | shifting in the address byte
// ADDR_ACK | acknowledging our address (9th clock)
// WR_DATA  | shifting in a byte written by the master
// WR_ACK   | acknowledging a written byte
// RD_DATA  | driving a read byte onto SDA, MSB first
// RD_ACK   | SDA released, sampling the master's ACK/NACK
// IGNORE   | not addressed or read finished, waiting for START/STOP
//
// Within ADDR_ACK / WR_ACK / RD_ACK the bit counter is reused as a phase flag:
// 0 = before the ACK-related edge, 1 = after it.
module i2c_slave_if
    import i2c_pkg::*;
#(
    parameter int unsigned              ADDR_WIDTH = 7,
    parameter int unsigned              DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]    SLAVE_ADDR = 7'h22
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  xfer_start_o,
    output logic                  op_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  wr_valid_o,
    output logic                  rd_req_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i,
    output logic                  xfer_done_o
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT  = BIT_CNT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] FULL_BYTE = BIT_CNT_W'(DATA_WIDTH);

    logic scl_s, scl_rise, scl_fall;
    logic sda_s, sda_rise, sda_fall;
    logic start_det, stop_det;
    logic [DATA_WIDTH-1:0] shift_in;

    i2c_state_t             state_q;
    logic [BIT_CNT_W-1:0]   bit_cnt_q;
    logic [DATA_WIDTH-1:0]  shift_q;
    logic                   sda_q;
    i2c_op_t                op_q;
    logic                   active_q;
    logic                   load_q;
    logic [DATA_WIDTH-1:0]  wr_data_q;
    logic                   wr_valid_q;
    logic                   rd_req_q;
    logic                   xfer_start_q;
    logic                   xfer_done_q;

    i2c_sync_edge u_scl_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (scl_i),
        .level_o (scl_s),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_sync_edge u_sda_sync (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .d_i     (sda_i),
        .level_o (sda_s),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    // Both lines share the same synchronizer latency, so the SCL level is aligned with the SDA edge
    assign start_det = sda_fall & scl_s;
    assign stop_det  = sda_rise & scl_s;
    assign shift_in  = {shift_q[DATA_WIDTH-2:0], sda_s};

    // Protocol FSM with registered bus drive and user-side pulses
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            sda_q        <= 1'b1;
            op_q         <= I2C_WRITE;
            active_q     <= 1'b0;
            load_q       <= 1'b0;
            wr_data_q    <= '0;
            wr_valid_q   <= 1'b0;
            rd_req_q     <= 1'b0;
            xfer_start_q <= 1'b0;
            xfer_done_q  <= 1'b0;
        end else begin
            xfer_start_q <= 1'b0;
            wr_valid_q   <= 1'b0;
            rd_req_q     <= 1'b0;
            xfer_done_q  <= 1'b0;

            // The user answers rd_req_o with data valid on the following cycle
            if (load_q) begin
                shift_q <= rd_data_i;
                load_q  <= 1'b0;
            end

            if (start_det) begin
                xfer_done_q <= active_q;
                active_q    <= 1'b0;
                load_q      <= 1'b0;
                sda_q       <= 1'b1;
                bit_cnt_q   <= '0;
                state_q     <= ADDR;
            end else if (stop_det) begin
                xfer_done_q <= active_q;
                active_q    <= 1'b0;
                load_q      <= 1'b0;
                sda_q       <= 1'b1;
                bit_cnt_q   <= '0;
                state_q     <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        sda_q <= 1'b1;
                    end

                    ADDR: begin
                        if (scl_rise) begin
                            shift_q <= shift_in;
                            if (bit_cnt_q == LAST_BIT) begin
                                bit_cnt_q <= '0;
                                if (shift_in[DATA_WIDTH-1 -: ADDR_WIDTH] == SLAVE_ADDR) begin
                                    xfer_start_q <= 1'b1;
                                    op_q         <= i2c_op_t'(shift_in[0]);
                                    active_q     <= 1'b1;
                                    state_q      <= ADDR_ACK;
                                end else begin
                                    state_q <= IGNORE;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end

                    ADDR_ACK: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == '0) begin
                                sda_q     <= 1'b0;
                                bit_cnt_q <= BIT_CNT_W'(1);
                                if (op_q == I2C_READ) begin
                                    rd_req_q <= 1'b1;
                                    load_q   <= 1'b1;
                                end
                            end else begin
                                bit_cnt_q <= '0;
                                if (op_q == I2C_READ) begin
                                    sda_q   <= shift_q[DATA_WIDTH-1];
                                    state_q <= RD_DATA;
                                end else begin
                                    sda_q   <= 1'b1;
                                    state_q <= WR_DATA;
                                end
                            end
                        end
                    end

                    WR_DATA: begin
                        if (scl_rise) begin
                            shift_q <= shift_in;
                            if (bit_cnt_q == LAST_BIT) begin
                                bit_cnt_q  <= '0;
                                wr_data_q  <= shift_in;
                                wr_valid_q <= 1'b1;
                                state_q    <= WR_ACK;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                    end

                    WR_ACK: begin
                        if (scl_fall) begin
                            if (bit_cnt_q == '0) begin
                                sda_q     <= 1'b0;
                                bit_cnt_q <= BIT_CNT_W'(1);
                            end else begin
                                sda_q     <= 1'b1;
                                bit_cnt_q <= '0;
                                state_q   <= WR_DATA;
                            end
                        end
                    end

                    // Counter counts SCL rises; each fall after a rise presents the next bit
                    RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end else if (scl_fall && (bit_cnt_q != '0)) begin
                            if (bit_cnt_q == FULL_BYTE) begin
                                sda_q     <= 1'b1;
                                bit_cnt_q <= '0;
                                state_q   <= RD_ACK;
                            end else begin
                                shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                                sda_q   <= shift_q[DATA_WIDTH-2];
                            end
                        end
                    end

                    RD_ACK: begin
                        if (scl_rise && (bit_cnt_q == '0)) begin
                            if (!sda_s) begin
                                rd_req_q  <= 1'b1;
                                load_q    <= 1'b1;
                                bit_cnt_q <= BIT_CNT_W'(1);
                            end else begin
                                state_q <= IGNORE;
                            end
                        end else if (scl_fall && (bit_cnt_q != '0)) begin
                            sda_q     <= shift_q[DATA_WIDTH-1];
                            bit_cnt_q <= '0;
                            state_q   <= RD_DATA;
                        end
                    end

                    IGNORE: begin
                        sda_q <= 1'b1;
                    end

                    default: begin
                        sda_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sda_o        = sda_q;
    assign op_o         = op_q;
    assign wr_data_o    = wr_data_q;
    assign wr_valid_o   = wr_valid_q;
    assign rd_req_o     = rd_req_q;
    assign xfer_start_o = xfer_start_q;
    assign xfer_done_o  = xfer_done_q;

endmodule

// File: tb/tb_i2c_slave_if.sv
// Directed bench for i2c_slave_if: a behavioural bus master drives SCL/SDA,
// a negedge monitor counts user-side pulses and answers read requests.
module tb_i2c_slave_if;
    import i2c_pkg::*;

    localparam int Q = 40;   // quarter SCL period in ns (SCL = 16 clk cycles)

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       m_sda = 1'b1;
    logic [7:0] rd_data = 8'd0;
    wire        sda_o;
    wire        sda_bus = m_sda & sda_o;
    wire        xfer_start, op, wr_valid, rd_req, xfer_done;
    wire [7:0]  wr_data;

    int tests = 0;
    int fails = 0;

    int n_start = 0, n_wrv = 0, n_rdreq = 0, n_done = 0, n_sda_low = 0;
    logic [7:0] wr_log [0:63];

    always #5 clk = ~clk;

    i2c_slave_if dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .scl_i        (scl),
        .sda_i        (sda_bus),
        .sda_o        (sda_o),
        .xfer_start_o (xfer_start),
        .op_o         (op),
        .wr_data_o    (wr_data),
        .wr_valid_o   (wr_valid),
        .rd_req_o     (rd_req),
        .rd_data_i    (rd_data),
        .xfer_done_o  (xfer_done)
    );

    // Pulse counters and read-data responder (data valid on the cycle after rd_req)
    always @(negedge clk) begin
        if (xfer_start) n_start++;
        if (wr_valid) begin
            if (n_wrv < 64) wr_log[n_wrv] = wr_data;
            n_wrv++;
        end
        if (rd_req) begin
            rd_data = 8'(100 + n_rdreq);
            n_rdreq++;
        end
        if (xfer_done) n_done++;
        if (!sda_o) n_sda_low++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        m_sda = 1'b0; #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q;
        scl = 1'b1;   #Q;
        m_sda = 1'b1; #Q;
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;  #Q;
        scl = 1'b1; #Q;
        #Q;
        scl = 1'b0; #Q;
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; #Q;
        scl = 1'b1;   #Q;
        b = sda_bus;  #Q;
        scl = 1'b0;   #Q;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic b;
        d = 8'h00;
        for (int i = 0; i < 8; i++) begin
            read_bit(b);
            d = {d[6:0], b};
        end
        write_bit(nack);
    endtask

    initial begin
        logic       ack;
        logic [7:0] rb;
        int b_start, b_wrv, b_rdreq, b_done, b_low;

        // Reset values
        #(3*Q);
        check("rst_sda", 32'(sda_o), 32'd1);
        check("rst_op", 32'(op), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_pulses", 32'({xfer_start, wr_valid, rd_req, xfer_done}), 32'd0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        #(2*Q);

        // Write 0x44 followed by 0x00..0x1F
        b_start = n_start; b_wrv = n_wrv; b_done = n_done;
        i2c_start();
        write_byte(8'h44, ack);
        check("wr_addr_ack", 32'(ack), 32'd0);
        check("wr_op", 32'(op), 32'd0);
        for (int i = 0; i < 32; i++) begin
            write_byte(8'(i), ack);
            check($sformatf("wr_ack%0d", i), 32'(ack), 32'd0);
        end
        i2c_stop();
        #(2*Q);
        check("wr_start_cnt", 32'(n_start - b_start), 32'd1);
        check("wr_valid_cnt", 32'(n_wrv - b_wrv), 32'd32);
        for (int i = 0; i < 32; i++)
            check($sformatf("wr_byte%0d", i), 32'(wr_log[b_wrv + i]), 32'(i));
        check("wr_done_cnt", 32'(n_done - b_done), 32'd1);

        // Read 0x45: 31 ACKed bytes, 32nd NACKed; responder supplies 100+i
        b_start = n_start; b_rdreq = n_rdreq; b_done = n_done;
        i2c_start();
        write_byte(8'h45, ack);
        check("rd_addr_ack", 32'(ack), 32'd0);
        check("rd_op", 32'(op), 32'd1);
        for (int i = 0; i < 32; i++) begin
            read_byte((i == 31), rb);
            check($sformatf("rd_byte%0d", i), 32'(rb), 32'(100 + i));
        end
        i2c_stop();
        #(2*Q);
        check("rd_start_cnt", 32'(n_start - b_start), 32'd1);
        check("rd_req_cnt", 32'(n_rdreq - b_rdreq), 32'd32);
        check("rd_done_cnt", 32'(n_done - b_done), 32'd1);

        // Foreign address 0x46 (0x23, write): never driven, no user pulses
        b_start = n_start; b_wrv = n_wrv; b_done = n_done; b_low = n_sda_low;
        i2c_start();
        write_byte(8'h46, ack);
        check("nm_ack_is_nack", 32'(ack), 32'd1);
        write_byte(8'h5A, ack);
        check("nm_data_nack", 32'(ack), 32'd1);
        i2c_stop();
        #(2*Q);
        check("nm_sda_low", 32'(n_sda_low - b_low), 32'd0);
        check("nm_start_cnt", 32'(n_start - b_start), 32'd0);
        check("nm_wrv_cnt", 32'(n_wrv - b_wrv), 32'd0);
        check("nm_done_cnt", 32'(n_done - b_done), 32'd0);

        // Write 0xA5, repeated START, read one byte NACKed
        b_done = n_done;
        i2c_start();
        write_byte(8'h44, ack);
        write_byte(8'hA5, ack);
        check("rs_wr_ack", 32'(ack), 32'd0);
        check("rs_wr_data", 32'(wr_data), 32'hA5);
        i2c_start();
        check("rs_done_at_rstart", 32'(n_done - b_done), 32'd1);
        write_byte(8'h45, ack);
        check("rs_addr_ack", 32'(ack), 32'd0);
        check("rs_op", 32'(op), 32'd1);
        read_byte(1'b1, rb);
        check("rs_rd_byte", 32'(rb), 32'd132);
        i2c_stop();
        #(2*Q);
        check("rs_done_total", 32'(n_done - b_done), 32'd2);

        // Reset while the slave holds ACK low: release must be immediate
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(8'h44 >> i);
        check("ack_driven_low", 32'(sda_o), 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_ack_release", 32'(sda_o), 32'd1);
        m_sda = 1'b1; scl = 1'b1;
        #(2*Q);
        rst_n = 1'b1;
        #(2*Q);

        // Reset during bit 5 of a data byte
        b_wrv = n_wrv;
        i2c_start();
        write_byte(8'h44, ack);
        check("rb_addr_ack", 32'(ack), 32'd0);
        write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
        m_sda = 1'b0; #Q;
        scl = 1'b1;   #Q;
        rst_n = 1'b0;
        #1;
        check("rb_sda_release", 32'(sda_o), 32'd1);
        m_sda = 1'b1;
        #(2*Q);
        check("rb_no_wrv", 32'(n_wrv - b_wrv), 32'd0);
        check("rb_state", 32'(dut.state_q), 32'(IDLE));
        rst_n = 1'b1;
        #(2*Q);

        b_wrv = n_wrv; b_done = n_done; b_start = n_start;
        i2c_start();
        write_byte(8'h44, ack);
        check("pr_addr_ack", 32'(ack), 32'd0);
        write_byte(8'h3C, ack);
        check("pr_data_ack", 32'(ack), 32'd0);
        i2c_stop();
        #(2*Q);
        check("pr_start_cnt", 32'(n_start - b_start), 32'd1);
        check("pr_wrv_cnt", 32'(n_wrv - b_wrv), 32'd1);
        check("pr_wr_data", 32'(wr_data), 32'h3C);
        check("pr_done_cnt", 32'(n_done - b_done), 32'd1);

        // STOP after 4 bits of a data byte
        b_wrv = n_wrv; b_done = n_done;
        i2c_start();
        write_byte(8'h44, ack);
        write_bit(1'b1); write_bit(1'b1); write_bit(1'b0); write_bit(1'b1);
        i2c_stop();
        #(2*Q);
        check("ps_no_wrv", 32'(n_wrv - b_wrv), 32'd0);
        check("ps_done_cnt", 32'(n_done - b_done), 32'd1);
        check("ps_state", 32'(dut.state_q), 32'(IDLE));
        check("ps_sda", 32'(sda_o), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/i2c_slave_if.md
# i2c_slave_if

Synthesizable single-address I2C slave responder with a parallel byte-level user interface. It sits on one I2C bus segment opposite a bus master such as the multi-bus controller. It decodes START/STOP conditions, matches its 7-bit address, ACKs and delivers written bytes, serves read bytes supplied by the user side, and reports transfer start and end.

## Interface
Parameters:
- ADDR_WIDTH, 7, I2C address width.
- DATA_WIDTH, 8, I2C data byte width.
- SLAVE_ADDR, 7'h22, address this slave responds to.

Ports:
- clk_i  in  1  system clock; one clock domain.
- rst_i  in  1  reset; asynchronous, active-low.
- scl_i  in  1  bus SCL, asynchronous to clk_i.
- sda_i  in  1  bus SDA, asynchronous to clk_i.
- sda_o  out  1  open-drain SDA drive: 0 pulls low, 1 releases.
- xfer_start_o  out  1  one-cycle pulse when the address byte matches.
- op_o  out  1  R/W bit of the matched address (1 = read); held until the next match.
- wr_data_o  out  DATA_WIDTH  last byte written by the master.
- wr_valid_o  out  1  one-cycle pulse when wr_data_o updates.
- rd_req_o  out  1  one-cycle pulse requesting the next read byte.
- rd_data_i  in  DATA_WIDTH  read byte; sampled the cycle after rd_req_o.
- xfer_done_o  out  1  one-cycle pulse at STOP or repeated START ending a matched transfer.

## Operation
- scl_i and sda_i pass through a 2-flop synchronizer. Edge detection uses the synchronized values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognized in every state.
- Bits are sampled on the synchronized SCL rising edge, MSB first. The slave changes sda_o only after a synchronized SCL falling edge.
- States:
  - IDLE: wait for START, then go to ADDR.
  - ADDR: shift in 8 bits.
    - If bits[7:1] == SLAVE_ADDR: pulse xfer_start_o, set op_o = bit0, go to ADDR_ACK.
    - Otherwise go to IGNORE, with sda_o left released.
  - ADDR_ACK: drive sda_o=0 for the 9th clock.
    - If op_o=1: pulse rd_req_o at the 8th-bit fall, load the byte, go to RD_DATA.
    - Otherwise go to WR_DATA.
  - WR_DATA: shift in 8 bits. Update wr_data_o and pulse wr_valid_o on the 8th rising edge, then go to WR_ACK.
  - WR_ACK: drive 0 for the 9th clock, then return to WR_DATA.
  - RD_DATA: drive the 8 bits of the shift register, MSB first, then release sda_o and go to RD_ACK.
  - RD_ACK: sample the master's bit on the 9th rising edge.
    - 0 (ACK): pulse rd_req_o, load the next byte at the 9th falling edge, go to RD_DATA.
    - 1 (NACK): go to IGNORE with no further rd_req_o.
  - IGNORE: keep sda_o released and wait for START or STOP.
- On STOP: release sda_o, go to IDLE, and pulse xfer_done_o if a matched transfer was active.
- On repeated START: pulse xfer_done_o if a transfer was active, then go to ADDR.
- START/STOP detection overrides any in-progress bit count. A partial byte is discarded with no wr_valid_o.
- No clock stretching. scl is never driven.

## Timing
- Reset values: sda_o=1, op_o=0, wr_data_o=0, and all pulse outputs 0. State is IDLE and bit counter is 0.
- Reset asserted mid-transfer releases sda_o immediately (asynchronous) and discards all progress.
- Bus-to-detection latency is 2 clk_i cycles from synchronization plus 1 cycle for edge registration.
- clk_i must be at least 8x the SCL frequency.
- rd_data_i must be stable the cycle after rd_req_o. It is loaded into the shift register on that cycle.
- ACK low is asserted by 3 clk_i cycles after the SCL fall that ends bit 8. It is released within 3 cycles after the SCL fall that ends bit 9.

## Structure
- Shared package i2c_pkg holds:
  - state enum: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
  - i2c_op_t: I2C_WRITE=0, I2C_READ=1.
- One sub-module, i2c_sync_edge: 2-flop synchronizer plus rise/fall detect. Instantiated once each for SCL and SDA.

## Test plan
- START, address 0x44, data bytes 0x00..0x1F, STOP:
  - ACK on all 33 bytes.
  - xfer_start_o with op_o=0.
  - 32 wr_valid_o pulses with wr_data_o = 0..31.
  - One xfer_done_o.
- START, address 0x45, master ACKs 31 bytes and NACKs the 32nd, STOP, with rd_data_i = 100+i:
  - Bus carries bytes 100..131.
  - Exactly 32 rd_req_o pulses.
  - One xfer_done_o.
- Address 0x46 (0x23, write):
  - sda_o stays 1 throughout, so the 9th bit reads NACK.
  - No xfer_start_o, wr_valid_o, or xfer_done_o.
- Write 0x44 with one byte 0xA5, then repeated START with 0x45 and a single read NACKed:
  - xfer_done_o pulses at the repeated START.
  - op_o becomes 1.
  - The read byte equals rd_data_i.
- rst_i low during bit 5 of a write data byte:
  - sda_o=1 immediately and no wr_valid_o.
  - After release, a new START/0x44 transfer completes normally.
- STOP after 4 bits of a data byte: no wr_valid_o, xfer_done_o pulses, state returns to IDLE.
